// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_MEM = 2'd1,
        ST_GNT_IF  = 2'd2
    } state_t;

    localparam logic [31:0] ABORT_RDATA = 32'h0;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: bus-wait counter with clear, enable and terminal-count detect
module mem_arb_timer #(
    parameter int TO_CYCLES = 64,
    parameter int TO_W      = 7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TO_CYCLES > 0 ? TO_CYCLES - 1 : 0);

    logic [TO_W-1:0] cnt;

    // tc fires on the enabled cycle that would bring the count to TO_CYCLES
    assign tc = (TO_CYCLES != 0) && en && (cnt == LAST);

    // count enabled cycles; cleared while idle so every grant starts at zero
    always_ff @(posedge clk_i) begin
        if (!rst_i || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between IF fetch and MEM load/store
// Optional MEM_ARB_PERF_EN adds saturating stall and conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 64,
    parameter int TO_W      = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_vld_o,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic [DW-1:0] mem_rdata_o,
    output logic          mem_vld_o,
    output logic          stall_o,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_ack_i,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]   perf_stall_cnt_o,
    output logic [31:0]   perf_conflict_cnt_o,
`endif
    output logic          err_o
);

    state_t state;
    logic   if_elig;
    logic   mem_elig;
    logic   ack;
    logic   tc;

    assign if_elig  = if_req_i & ~if_vld_o;
    assign mem_elig = mem_req_i & ~mem_vld_o;
    assign stall_o  = if_elig | mem_elig;
    assign ack      = bus_ack_i & bus_req_o;

    mem_arb_timer #(
        .TO_CYCLES(TO_CYCLES),
        .TO_W     (TO_W)
    ) u_timer (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr  (state == ST_IDLE),
        .en   ((state != ST_IDLE) & ~ack),
        .tc   (tc)
    );

    // grant MEM before IF, run the bus handshake, and hold results until the pipeline advances
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_rdata_o  <= '0;
            if_vld_o    <= 1'b0;
            mem_rdata_o <= '0;
            mem_vld_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (!stall_o) begin
                if_vld_o  <= 1'b0;
                mem_vld_o <= 1'b0;
            end
            if (state == ST_IDLE) begin
                if (mem_elig) begin
                    state       <= ST_GNT_MEM;
                    bus_req_o   <= 1'b1;
                    bus_we_o    <= mem_we_i;
                    bus_addr_o  <= mem_addr_i;
                    bus_wdata_o <= mem_wdata_i;
                end else if (if_elig) begin
                    state      <= ST_GNT_IF;
                    bus_req_o  <= 1'b1;
                    bus_we_o   <= 1'b0;
                    bus_addr_o <= if_addr_i;
                end
            end else if (ack || tc) begin
                state     <= ST_IDLE;
                bus_req_o <= 1'b0;
                err_o     <= ~ack;
                if (state == ST_GNT_MEM) begin
                    mem_vld_o <= 1'b1;
                    if (!bus_we_o)
                        mem_rdata_o <= ack ? bus_rdata_i : DW'(ABORT_RDATA);
                end else begin
                    if_vld_o   <= 1'b1;
                    if_rdata_o <= ack ? bus_rdata_i : DW'(ABORT_RDATA);
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    // saturating counts of stalled cycles and idle cycles with both ports contending
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_stall_cnt_o    <= '0;
            perf_conflict_cnt_o <= '0;
        end else begin
            if (stall_o && perf_stall_cnt_o != '1)
                perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
            if (state == ST_IDLE && if_elig && mem_elig && perf_conflict_cnt_o != '1)
                perf_conflict_cnt_o <= perf_conflict_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (TO_CYCLES=4)
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_vld_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_vld_o;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        err_o;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_conflict_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int stall_seen = 0;
    int if20_cycles = 0;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TO_CYCLES(4), .TO_W(4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_vld_o   (if_vld_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_vld_o  (mem_vld_o),
        .stall_o    (stall_o),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i  (bus_ack_i),
`ifdef MEM_ARB_PERF_EN
        .perf_stall_cnt_o   (perf_stall_cnt_o),
        .perf_conflict_cnt_o(perf_conflict_cnt_o),
`endif
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    // observe stalled cycles and bus cycles spent on the IF address 0x20
    always @(negedge clk_i) begin
        if (rst_i && stall_o) stall_seen++;
        if (bus_req_o && bus_addr_o == 32'h20) if20_cycles++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_conflict(input logic [31:0] prev_mdata);
        if_req_i = 1'b1; if_addr_i = 32'h8;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h10; mem_wdata_i = 32'hAA;
        bus_rdata_i = 32'hBAD;
        #1;
        chk("c_stall0", 32'(stall_o), 1);
        tick;
        chk("c_req_st", 32'(bus_req_o), 1);
        chk("c_we_st", 32'(bus_we_o), 1);
        chk("c_addr_st", bus_addr_o, 32'h10);
        chk("c_wdata_st", bus_wdata_o, 32'hAA);
        tick;
        chk("c_req_wait", 32'(bus_req_o), 1);
        chk("c_stall1", 32'(stall_o), 1);
        bus_ack_i = 1'b1;
        tick;
        chk("c_mvld", 32'(mem_vld_o), 1);
        chk("c_mrdata_keep", mem_rdata_o, prev_mdata);
        chk("c_req_gap", 32'(bus_req_o), 0);
        chk("c_stall2", 32'(stall_o), 1);
        chk("c_ivld0", 32'(if_vld_o), 0);
        bus_ack_i = 1'b0;
        tick;
        chk("c_req_if", 32'(bus_req_o), 1);
        chk("c_addr_if", bus_addr_o, 32'h8);
        chk("c_we_if", 32'(bus_we_o), 0);
        tick;
        chk("c_req_if_wait", 32'(bus_req_o), 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h13;
        tick;
        chk("c_ivld", 32'(if_vld_o), 1);
        chk("c_irdata", if_rdata_o, 32'h13);
        chk("c_mvld_hold", 32'(mem_vld_o), 1);
        chk("c_stall_low", 32'(stall_o), 0);
        chk("c_req_done", 32'(bus_req_o), 0);
        bus_ack_i = 1'b0; if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        tick;
        chk("c_ivld_clr", 32'(if_vld_o), 0);
        chk("c_mvld_clr", 32'(mem_vld_o), 0);
    endtask

    initial begin
        int snap;
        rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
        tick; tick;
        chk("rst_req", 32'(bus_req_o), 0);
        chk("rst_we", 32'(bus_we_o), 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_wdata", bus_wdata_o, 0);
        chk("rst_ivld", 32'(if_vld_o), 0);
        chk("rst_mvld", 32'(mem_vld_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_irdata", if_rdata_o, 0);
        chk("rst_mrdata", mem_rdata_o, 0);
        rst_i = 1'b1;

        mem_req_i = 1'b1; mem_addr_i = 32'h40;
        #1;
        chk("t1_stall", 32'(stall_o), 1);
        chk("t1_req0", 32'(bus_req_o), 0);
        tick;
        chk("t1_req", 32'(bus_req_o), 1);
        chk("t1_addr", bus_addr_o, 32'h40);
        chk("t1_we", 32'(bus_we_o), 0);
        chk("t1_vld0", 32'(mem_vld_o), 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234;
        tick;
        chk("t1_vld", 32'(mem_vld_o), 1);
        chk("t1_rdata", mem_rdata_o, 32'h1234);
        chk("t1_stall_low", 32'(stall_o), 0);
        chk("t1_req_low", 32'(bus_req_o), 0);
        bus_ack_i = 1'b0; mem_req_i = 1'b0;
        tick;
        chk("t1_vld_clr", 32'(mem_vld_o), 0);

        run_conflict(32'h1234);

        if_req_i = 1'b1; if_addr_i = 32'h20;
        tick;
        chk("t3_req_if", 32'(bus_req_o), 1);
        mem_req_i = 1'b1; mem_addr_i = 32'h44; bus_ack_i = 1'b1; bus_rdata_i = 32'h55;
        tick;
        chk("t3_ivld", 32'(if_vld_o), 1);
        chk("t3_irdata", if_rdata_o, 32'h55);
        chk("t3_stall", 32'(stall_o), 1);
        bus_ack_i = 1'b0;
        tick;
        chk("t3_req_mem", 32'(bus_req_o), 1);
        chk("t3_addr_mem", bus_addr_o, 32'h44);
        tick;
        chk("t3_addr_hold", bus_addr_o, 32'h44);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h66;
        tick;
        chk("t3_mvld", 32'(mem_vld_o), 1);
        chk("t3_mrdata", mem_rdata_o, 32'h66);
        chk("t3_ivld_hold", 32'(if_vld_o), 1);
        chk("t3_stall_low", 32'(stall_o), 0);
        bus_ack_i = 1'b0; if_req_i = 1'b0; mem_req_i = 1'b0;
        tick;
        chk("t3_vld_clr", 32'({if_vld_o, mem_vld_o}), 0);
        chk("t3_if_bus_cycles", 32'(if20_cycles), 1);

        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h80;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t4_req_held", 32'(bus_req_o), 1);
            chk("t4_err_low", 32'(err_o), 0);
        end
        tick;
        chk("t4_req_drop", 32'(bus_req_o), 0);
        chk("t4_err", 32'(err_o), 1);
        chk("t4_mvld", 32'(mem_vld_o), 1);
        chk("t4_mrdata", mem_rdata_o, 32'h0);
        mem_req_i = 1'b0;
        tick;
        chk("t4_err_pulse", 32'(err_o), 0);
        chk("t4_mvld_clr", 32'(mem_vld_o), 0);

        if_req_i = 1'b1; if_addr_i = 32'h30;
        tick;
        chk("t5_req_if", 32'(bus_req_o), 1);
        rst_i = 1'b0;
        tick;
        chk("t5_rst_req", 32'(bus_req_o), 0);
        chk("t5_rst_addr", bus_addr_o, 0);
        chk("t5_rst_ivld", 32'(if_vld_o), 0);
        chk("t5_rst_mrdata", mem_rdata_o, 0);
        rst_i = 1'b1; if_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD;
        tick;
        chk("t5_stray_vld", 32'(if_vld_o), 0);
        chk("t5_stray_rdata", if_rdata_o, 0);
        chk("t5_stray_req", 32'(bus_req_o), 0);
        bus_ack_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h34;
        tick;
        chk("t5_req_new", 32'(bus_req_o), 1);
        chk("t5_addr_new", bus_addr_o, 32'h34);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h77;
        tick;
        chk("t5_ivld", 32'(if_vld_o), 1);
        chk("t5_irdata", if_rdata_o, 32'h77);
        bus_ack_i = 1'b0; if_req_i = 1'b0;
        tick;
        chk("t5_ivld_clr", 32'(if_vld_o), 0);

`ifdef MEM_ARB_PERF_EN
        rst_i = 1'b0;
        tick; tick;
        rst_i = 1'b1;
        snap = stall_seen;
        run_conflict(32'h0);
        chk("t6_conflict", perf_conflict_cnt_o, 1);
        chk("t6_stall_cnt", perf_stall_cnt_o, 6);
        chk("t6_stall_obs", perf_stall_cnt_o, 32'(stall_seen - snap));
`else
        snap = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
